// File: rtl/gb_pkg.sv
// Shared definitions for the multi-lane global buffer: FSM encoding and the
// lane packing helper used to slice the flat LANES*DATA_BITS buses.
package gb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } gbState_e;

   // Lane i of a packed bus starts at bit i*dataBits.
   function automatic int unsigned laneLsb(input int unsigned lane, input int unsigned dataBits);
      return lane * dataBits;
   endfunction

endpackage

// File: rtl/gb_bank.sv
// One lane of the global buffer: simple dual-port RAM with a registered,
// read-first read port. The array itself carries no reset so it maps to BRAM.
module gb_bank #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wrEn_i,
   input  logic [ADDR_BITS-1:0] wrAddr_i,
   input  logic [DATA_BITS-1:0] wrData_i,
   input  logic                 rdEn_i,
   input  logic [ADDR_BITS-1:0] rdAddr_i,
   output logic [DATA_BITS-1:0] rdData_o
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [DATA_BITS-1:0] rdData_q;

   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem[wrAddr_i] <= wrData_i;
      end
   end

   // Non-blocking read of the array gives old data on a same-address write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= mem[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/global_buffer_mlane.sv
// Multi-lane global buffer: LANES independent banks sharing one address,
// per-lane write masking, and a DEPTH-cycle zero-fill sweep on clr_req.
module global_buffer_mlane
   import gb_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int LANES     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_req,
   output logic                       busy,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [ADDR_BITS-1:0]       wr_addr,
   input  logic [LANES-1:0]           wr_mask,
   input  logic [LANES*DATA_BITS-1:0] wr_data,
   input  logic                       rd_valid,
   output logic                       rd_ready,
   input  logic [ADDR_BITS-1:0]       rd_addr,
   output logic [LANES*DATA_BITS-1:0] rd_data,
   output logic                       rd_data_valid
);

   gbState_e             state_q, state_d;
   logic [ADDR_BITS-1:0] cnt_q, cnt_d;
   logic                 rdValid_q;
   logic                 clearing;
   logic                 wrAccept;
   logic                 rdAccept;
   logic [ADDR_BITS-1:0] bankWrAddr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rdValid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdValid_q <= rdAccept;
      end
   end

   // The sweep leaves CLEAR right after the last address, so cnt wraps to 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_BITS'(1);
            if (cnt_q == {ADDR_BITS{1'b1}}) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      clearing = (state_q == CLEAR);
      busy     = clearing;
      wr_ready = !clearing;
      rd_ready = !clearing;
   end

   assign wrAccept      = wr_valid && wr_ready;
   assign rdAccept      = rd_valid && rd_ready;
   assign bankWrAddr    = clearing ? cnt_q : wr_addr;
   assign rd_data_valid = rdValid_q;

   for (genvar i = 0; i < LANES; i++) begin : gLane
      logic                 laneWe;
      logic [DATA_BITS-1:0] laneWrData;

      assign laneWe     = clearing || (wrAccept && wr_mask[i]);
      assign laneWrData = clearing ? '0 : wr_data[laneLsb(i, DATA_BITS) +: DATA_BITS];

      gb_bank #(
         .ADDR_BITS(ADDR_BITS),
         .DATA_BITS(DATA_BITS)
      ) uBank (
         .clk     (clk),
         .rst     (rst),
         .wrEn_i  (laneWe),
         .wrAddr_i(bankWrAddr),
         .wrData_i(laneWrData),
         .rdEn_i  (rdAccept),
         .rdAddr_i(rd_addr),
         .rdData_o(rd_data[laneLsb(i, DATA_BITS) +: DATA_BITS])
      );
   end

endmodule

// File: tb/tb_global_buffer_mlane.sv
// Self-checking bench for global_buffer_mlane: a directed vector table for
// single-cycle behaviour plus hand-written clear, abort and streaming sequences.
module tb_global_buffer_mlane;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_req = 1'b0;
   logic        busy;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [7:0]  wr_addr = '0;
   logic [3:0]  wr_mask = '0;
   logic [31:0] wr_data = '0;
   logic        rd_valid = 1'b0;
   logic        rd_ready;
   logic [7:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_data_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wrValid;
      logic [7:0]  wrAddr;
      logic [3:0]  wrMask;
      logic [31:0] wrData;
      logic        rdValid;
      logic [7:0]  rdAddr;
      logic        expValid;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs [13];

   global_buffer_mlane #(
      .ADDR_BITS(8),
      .DATA_BITS(8),
      .LANES    (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clr_req      (clr_req),
      .busy         (busy),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_mask      (wr_mask),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_data_valid(rd_data_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      wr_valid = v.wrValid;
      wr_addr  = v.wrAddr;
      wr_mask  = v.wrMask;
      wr_data  = v.wrData;
      rd_valid = v.rdValid;
      rd_addr  = v.rdAddr;
   endtask

   task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expData);
      check({tag, " valid"}, 32'(rd_data_valid), 32'(expValid));
      check({tag, " data"}, rd_data, expData);
   endtask

   task automatic writeWord(input logic [7:0] addr, input logic [31:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_mask  = 4'hF;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [7:0] addr, input logic [31:0] exp);
      rd_valid = 1'b1;
      rd_addr  = addr;
      tick();
      rd_valid = 1'b0;
      checkOutput(name, 1'b1, exp);
   endtask

   function automatic logic [31:0] streamPat(input int i);
      return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
   endfunction

   function automatic logic [31:0] abortPat(input int i);
      return {8'hC0, 8'(i), 8'h5A, 8'(i)};
   endfunction

   initial begin
      int busyCycles;
      int badCycles;

      vecs[0]  = '{1'b1, 8'd5,   4'hF, 32'h44332211, 1'b0, 8'd0,   1'b0, 32'h00000000};
      vecs[1]  = '{1'b0, 8'd0,   4'h0, 32'h00000000, 1'b1, 8'd5,   1'b1, 32'h44332211};
      vecs[2]  = '{1'b1, 8'd5,   4'h2, 32'hFFFFFFFF, 1'b0, 8'd0,   1'b0, 32'h44332211};
      vecs[3]  = '{1'b0, 8'd0,   4'h0, 32'h00000000, 1'b1, 8'd5,   1'b1, 32'h4433FF11};
      vecs[4]  = '{1'b1, 8'd7,   4'hF, 32'h01020304, 1'b0, 8'd0,   1'b0, 32'h4433FF11};
      vecs[5]  = '{1'b1, 8'd7,   4'hF, 32'hAAAAAAAA, 1'b1, 8'd7,   1'b1, 32'h01020304};
      vecs[6]  = '{1'b0, 8'd0,   4'h0, 32'h00000000, 1'b1, 8'd7,   1'b1, 32'hAAAAAAAA};
      vecs[7]  = '{1'b1, 8'd5,   4'h9, 32'h99887766, 1'b0, 8'd0,   1'b0, 32'hAAAAAAAA};
      vecs[8]  = '{1'b0, 8'd0,   4'h0, 32'h00000000, 1'b1, 8'd5,   1'b1, 32'h9933FF66};
      vecs[9]  = '{1'b1, 8'd5,   4'h0, 32'h00000000, 1'b0, 8'd0,   1'b0, 32'h9933FF66};
      vecs[10] = '{1'b1, 8'd255, 4'hF, 32'hDEADBEEF, 1'b1, 8'd5,   1'b1, 32'h9933FF66};
      vecs[11] = '{1'b1, 8'd0,   4'hF, 32'h13579BDF, 1'b1, 8'd255, 1'b1, 32'hDEADBEEF};
      vecs[12] = '{1'b0, 8'd0,   4'h0, 32'h00000000, 1'b1, 8'd0,   1'b1, 32'h13579BDF};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset wr_ready", 32'(wr_ready), 32'd1);
      check("reset rd_ready", 32'(rd_ready), 32'd1);
      checkOutput("reset", 1'b0, 32'h0);
      rst = 1'b0;
      tick();

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData);
      end
      wr_valid = 1'b0;
      rd_valid = 1'b0;

      // Back-to-back streaming reads
      for (int i = 0; i < 16; i++) begin
         writeWord(8'(i), streamPat(i));
      end
      rd_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd_addr = 8'(i);
         tick();
         checkOutput($sformatf("stream%0d", i), 1'b1, streamPat(i));
      end
      rd_valid = 1'b0;
      tick();
      checkOutput("stream end", 1'b0, streamPat(15));

      // Clear sweep with a read accepted in the request cycle
      writeWord(8'd5, 32'h9933FF66);
      clr_req  = 1'b1;
      rd_valid = 1'b1;
      rd_addr  = 8'd5;
      tick();
      clr_req = 1'b0;
      check("clear entry busy", 32'(busy), 32'd1);
      check("clear entry wr_ready", 32'(wr_ready), 32'd0);
      check("clear entry rd_ready", 32'(rd_ready), 32'd0);
      checkOutput("clear entry read", 1'b1, 32'h9933FF66);
      busyCycles = busy ? 1 : 0;
      badCycles  = 0;
      wr_valid = 1'b1;
      wr_addr  = 8'd3;
      wr_mask  = 4'hF;
      wr_data  = 32'hDEADBEEF;
      rd_addr  = 8'd3;
      for (int k = 0; k < 400 && busy; k++) begin
         clr_req = (busyCycles == 50);
         tick();
         if (busy) begin
            busyCycles++;
            if (rd_data_valid || wr_ready || rd_ready) badCycles++;
         end
      end
      clr_req  = 1'b0;
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      check("clear busy cycles", 32'(busyCycles), 32'd256);
      check("clear blocked handshakes", 32'(badCycles), 32'd0);
      readCheck("clear addr0", 8'd0, 32'h0);
      readCheck("clear addr3", 8'd3, 32'h0);
      readCheck("clear addr5", 8'd5, 32'h0);
      readCheck("clear addr7", 8'd7, 32'h0);
      readCheck("clear addr255", 8'd255, 32'h0);
      check("clear no restart", 32'(busy), 32'd0);

      // Reset during sweep aborts it after addresses 0..99
      for (int i = 0; i < 128; i++) begin
         writeWord(8'(i), abortPat(i));
      end
      writeWord(8'd200, 32'h0BADF00D);
      readCheck("abort preload", 8'd50, abortPat(50));
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (100) tick();
      rst      = 1'b1;
      rd_valid = 1'b1;
      rd_addr  = 8'd200;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("abort outputs", 1'b0, 32'h0);
      tick();
      check("abort read under reset", 32'(rd_data_valid), 32'd0);
      rst      = 1'b0;
      rd_valid = 1'b0;
      tick();
      check("abort idle busy", 32'(busy), 32'd0);
      check("abort no strobe", 32'(rd_data_valid), 32'd0);
      readCheck("abort addr0", 8'd0, 32'h0);
      readCheck("abort addr50", 8'd50, 32'h0);
      readCheck("abort addr99", 8'd99, 32'h0);
      readCheck("abort addr100", 8'd100, abortPat(100));
      readCheck("abort addr127", 8'd127, abortPat(127));
      readCheck("abort addr200", 8'd200, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
